accel_tick_averager: RTL
========================

Name: accel_tick_averager

Overview:
Avalon-MM slave downstream of the 16-bit interval timer. It uses the timer's timeout output as a sample tick and captures one signed accelerometer reading on each tick. It box-car averages 2^shift readings and pushes each result into an 8-deep FIFO that the Nios reads. It raises irq when the FIFO fill level reaches a programmable threshold.

Parameters:
DATA_W, 16, sample and result width (signed)
FIFO_DEPTH, 8, result FIFO entries (power of 2)
MAX_SHIFT, 4, largest averaging exponent; accumulator width is DATA_W+MAX_SHIFT

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
tick  in  1  level from timer irq/timeout; rising edge = sample request
sample_data  in  DATA_W  signed accelerometer reading, stable around tick
address  in  3  Avalon word address
chipselect  in  1  Avalon select
read  in  1  Avalon read strobe
write_n  in  1  Avalon write, active-low
writedata  in  16  Avalon write data
readdata  out  16  Avalon read data, registered
irq  out  1  level interrupt

Behaviour:
- Reset values: readdata=0, irq=0, FIFO empty, overflow=0, control=0, thresh=1, accumulator=0, count=0, tick_d=0.
- Edge detect: tick_rise = tick & ~tick_d; tick_d registered every cycle. A tick held high gives exactly one sample.
- Register map (readdata <= mux(address) every cycle; 1-cycle read latency; unmapped addresses read 0):
  - 0 STATUS (R):
    - [0] nonempty
    - [1] overflow (sticky)
    - [7:4] fill (0..8)
    - Write any value: clears overflow.
  - 1 CONTROL (R/W):
    - [0] enable
    - [1] irq_en
    - [4:2] shift; written values > MAX_SHIFT are stored as MAX_SHIFT
    - [5] flush; write-only strobe, reads 0
  - 2 DATA (R): FIFO head. Read strobe (chipselect & read & address==2 & nonempty) pops in the same cycle the head is latched into readdata. Reading DATA when empty returns 0 with no pop.
  - 3 THRESH (R/W): [3:0] threshold; a written 0 is stored as 1, values > 8 are stored as 8.
- Averaging, on tick_rise with enable=1:
  - sum = acc + sign-extended sample_data.
  - If count == 2^shift-1: push result = sum >>> shift (arithmetic, truncated to DATA_W), then acc=0, count=0.
  - Otherwise acc=sum and count++.
  - Push and fill update occur on that same clock edge.
  - tick_rise with enable=0 is ignored.
  - shift=0 gives a pass-through of each sample.
- A CONTROL write clears acc and count, so a partial average is discarded whenever shift or enable changes.
- Flush strobe: clears FIFO pointers/fill, acc and count in one cycle. It does not clear overflow. A push in the same cycle is discarded.
- FIFO full and push with no pop: result dropped, overflow set, contents unchanged.
- Full with simultaneous pop and push: both succeed, fill stays 8, no overflow.
- Empty with simultaneous push and pop: pop is not possible (nonempty=0); push succeeds, fill becomes 1.
- Simultaneous STATUS write and overflow event: set wins.
- irq: registered, = irq_en & (fill >= thresh), evaluated on the post-update fill, so irq asserts one cycle after the push that meets the threshold.
- Asynchronous reset mid-accumulation discards the partial sum and all FIFO contents immediately.

Decomposition:
- Shared package accel_avg_pkg:
  - register address constants (ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_DATA=2, ADDR_THRESH=3)
  - STATUS/CONTROL bit-position constants
  - DATA_W/MAX_SHIFT defaults
- One sub-module, accel_avg_fifo:
  - synchronous FIFO with push, pop, flush, full, empty, fill and head outputs
  - same clk/reset_n
- Top level holds the edge detector, accumulator, register file and irq.

Test Plan:
- shift=0, enable=1; ticks with samples 100, -5 → DATA reads 100 then 0xFFFB; STATUS fill 2→1→0, nonempty clears after second read.
- shift=2; samples -1,-2,-3,-4 → one push of -10>>>2 = -3 (0xFFFD); no push after only 3 ticks; tick held high 10 cycles → counts as 1 sample.
- shift=0; 9 ticks with no reads → fill=8, overflow=1, first 8 values intact in order; STATUS write → overflow=0.
- FIFO full; tick on the same cycle as a DATA read → readdata=oldest entry, fill stays 8, overflow stays 0.
- THRESH=3, irq_en=1; 2 pushes → irq=0; 3rd push → irq=1 next cycle; one DATA read → irq=0; writing THRESH=0 reads back 1.
- shift=3 after 5 ticks: flush → fill=0, next average needs 8 fresh ticks. Separately, reset_n low mid-accumulation → readdata=0, irq=0, STATUS=0.

Source files
------------

// File: rtl/accel_avg_pkg.sv
// Shared constants for the tick-driven accelerometer averager: register map,
// register bit positions and default sizing.
package accel_avg_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int MAX_SHIFT_DEF  = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_DATA    = 3'd2;
    localparam logic [2:0] ADDR_THRESH  = 3'd3;

    localparam int ST_NONEMPTY = 0;
    localparam int ST_OVERFLOW = 1;
    localparam int ST_FILL_LSB = 4;

    localparam int CT_ENABLE    = 0;
    localparam int CT_IRQ_EN    = 1;
    localparam int CT_SHIFT_LSB = 2;
    localparam int CT_FLUSH     = 5;

endpackage

// File: rtl/accel_avg_fifo.sv
// Result FIFO for the averager: push/pop/flush with fill count and a
// combinational head. Flush has priority over any push or pop in that cycle.
module accel_avg_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int FW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_full,
    output logic              o_empty,
    output logic [FW-1:0]     o_fill,
    output logic [DATA_W-1:0] o_head
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [AW-1:0]                r_wr_ptr;
    logic [AW-1:0]                r_rd_ptr;
    logic [FW-1:0]                r_fill;
    logic                         w_do_pop;
    logic                         w_do_push;

    assign o_full  = (r_fill == FW'(DEPTH));
    assign o_empty = (r_fill == '0);
    assign o_fill  = r_fill;
    assign o_head  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/accel_tick_averager.sv
// Avalon-MM slave: samples the accelerometer on each timer tick edge, box-car
// averages 2^shift samples, queues results for the CPU and raises a fill irq.
module accel_tick_averager
    import accel_avg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MAX_SHIFT  = MAX_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq
);

    localparam int ACC_W = DATA_W + MAX_SHIFT;
    localparam int SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int FW    = $clog2(FIFO_DEPTH) + 1;

    logic                    r_tick_d;
    logic                    r_enable;
    logic                    r_irq_en;
    logic [SH_W-1:0]         r_shift;
    logic [FW-1:0]           r_thresh;
    logic                    r_ovf;
    logic signed [ACC_W-1:0] r_acc;
    logic [MAX_SHIFT-1:0]    r_count;
    logic [15:0]             r_rdata;
    logic                    r_irq;

    logic                    w_tick_rise;
    logic                    w_wr;
    logic                    w_ctrl_wr;
    logic                    w_stat_wr;
    logic                    w_thr_wr;
    logic                    w_flush;
    logic                    w_sample_go;
    logic                    w_last;
    logic [MAX_SHIFT:0]      w_count_max;
    logic signed [ACC_W-1:0] w_sext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [FW-1:0]           w_fill;
    logic [DATA_W-1:0]       w_head;
    logic [2:0]              w_wr_shift;
    logic [3:0]              w_wr_thresh;
    logic [SH_W-1:0]         w_shift_clamped;
    logic [FW-1:0]           w_thresh_clamped;
    logic [15:0]             w_rdata;

    assign w_tick_rise = tick & ~r_tick_d;
    assign w_wr        = chipselect & ~write_n;
    assign w_ctrl_wr   = w_wr & (address == ADDR_CONTROL);
    assign w_stat_wr   = w_wr & (address == ADDR_STATUS);
    assign w_thr_wr    = w_wr & (address == ADDR_THRESH);
    assign w_flush     = w_ctrl_wr & writedata[CT_FLUSH];

    // Any CONTROL write restarts the average, so a tick in that cycle is dropped.
    assign w_sample_go = w_tick_rise & r_enable & ~w_ctrl_wr;
    assign w_count_max = (MAX_SHIFT+1)'((1 << r_shift) - 1);
    assign w_last      = ({1'b0, r_count} == w_count_max);
    assign w_sext      = {{MAX_SHIFT{sample_data[DATA_W-1]}}, sample_data};
    assign w_sum       = r_acc + w_sext;
    assign w_shifted   = w_sum >>> r_shift;
    assign w_push      = w_sample_go & w_last;
    assign w_pop       = chipselect & read & (address == ADDR_DATA) & ~w_empty;

    assign w_wr_shift       = writedata[CT_SHIFT_LSB +: 3];
    assign w_shift_clamped  = (w_wr_shift > 3'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT) : SH_W'(w_wr_shift);
    assign w_wr_thresh      = writedata[3:0];
    assign w_thresh_clamped = (w_wr_thresh == 4'd0)              ? FW'(1) :
                              (w_wr_thresh > 4'(FIFO_DEPTH))     ? FW'(FIFO_DEPTH) :
                                                                   FW'(w_wr_thresh);

    accel_avg_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_shifted[DATA_W-1:0]),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_fill      (w_fill),
        .o_head      (w_head)
    );

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS: begin
                w_rdata[ST_NONEMPTY]       = ~w_empty;
                w_rdata[ST_OVERFLOW]       = r_ovf;
                w_rdata[ST_FILL_LSB +: FW] = w_fill;
            end
            ADDR_CONTROL: begin
                w_rdata[CT_ENABLE]              = r_enable;
                w_rdata[CT_IRQ_EN]              = r_irq_en;
                w_rdata[CT_SHIFT_LSB +: SH_W]   = r_shift;
            end
            ADDR_DATA:   if (!w_empty) w_rdata[DATA_W-1:0] = w_head;
            ADDR_THRESH: w_rdata[FW-1:0] = r_thresh;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_d <= 1'b0;
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_shift  <= '0;
            r_thresh <= FW'(1);
            r_ovf    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_tick_d <= tick;
            r_rdata  <= w_rdata;
            r_irq    <= r_irq_en & (w_fill >= r_thresh);
            if (w_ctrl_wr) begin
                r_enable <= writedata[CT_ENABLE];
                r_irq_en <= writedata[CT_IRQ_EN];
                r_shift  <= w_shift_clamped;
            end
            if (w_thr_wr) r_thresh <= w_thresh_clamped;
            // A drop on a full FIFO outranks a simultaneous STATUS clear.
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
            else if (w_stat_wr)           r_ovf <= 1'b0;
            if (w_ctrl_wr) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_sample_go) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_count <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign readdata = r_rdata;
    assign irq      = r_irq;

endmodule
